// File: rtl/xc_aesmix_seq_if.sv
// ---------------------------------------------------------------------------
// xc_aesmix_seq_if
// Request/response bundle for the xc_aesmix_seq MixColumns unit.
//   valid  : request, held by the requester until ready is seen
//   enc    : 1 = MixColumns, 0 = InvMixColumns
//   state  : NCOL x 32-bit AES state, column c at [32c+31:32c], row r = byte r
//   shift  : (only with XC_AESMIX_SEQ_SHIFTROWS_EN) apply (Inv)ShiftRows first
//   ready  : single-cycle result pulse
//   result : mixed state, all-zero whenever ready is low
// Modports: master = requester side, slave = functional unit side.
// ---------------------------------------------------------------------------
interface xc_aesmix_seq_if #(
  parameter int NCOL = 4
) ();
  logic              valid;
  logic              enc;
  logic [32*NCOL-1:0] state;
`ifdef XC_AESMIX_SEQ_SHIFTROWS_EN
  logic              shift;
`endif
  logic              ready;
  logic [32*NCOL-1:0] result;

`ifdef XC_AESMIX_SEQ_SHIFTROWS_EN
  modport master (output valid, enc, state, shift, input ready, result);
  modport slave  (input valid, enc, state, shift, output ready, result);
`else
  modport master (output valid, enc, state, input ready, result);
  modport slave  (input valid, enc, state, output ready, result);
`endif
endinterface

// File: rtl/xc_aesmix_seq.sv
// ---------------------------------------------------------------------------
// xc_aesmix_seq
// Iterative AES MixColumns / InvMixColumns over a full NCOL-column state,
// COLS_PER_CYCLE columns mixed per busy cycle, result returned as a one-cycle
// ready pulse with an OR-mergeable (zero when idle) result bus.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset
//   bus   : xc_aesmix_seq_if.slave (valid/enc/state in, ready/result out)
// Optional feature macro: XC_AESMIX_SEQ_SHIFTROWS_EN adds bus.shift; when set
// at accept, the state is latched through ShiftRows (enc=1) or InvShiftRows
// (enc=0) with no latency change.
// ---------------------------------------------------------------------------
module xc_aesmix_seq #(
  parameter int NCOL           = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic           clock,
  input  logic           reset,
  xc_aesmix_seq_if.slave bus
);
  localparam int W  = 32 * NCOL;
  localparam int CW = $clog2(NCOL) + 1;

  generate
    if (NCOL < 1 || NCOL > 8) begin : g_bad_ncol
      $error("xc_aesmix_seq: NCOL must be in 1..8");
    end
    if (COLS_PER_CYCLE < 1) begin : g_bad_cpc
      $error("xc_aesmix_seq: COLS_PER_CYCLE must be at least 1");
    end else if ((NCOL % COLS_PER_CYCLE) != 0) begin : g_bad_div
      $error("xc_aesmix_seq: COLS_PER_CYCLE must divide NCOL");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  // GF(2^8) multiply by x, reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic fwd);
    logic [7:0]  b  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] o;
    for (int r = 0; r < 4; r++) begin
      b[r]  = col[8*r +: 8];
      x2[r] = xtime(b[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    o = '0;
    for (int r = 0; r < 4; r++) begin
      if (fwd) begin
        // 2*b[r] ^ 3*b[r+1] ^ b[r+2] ^ b[r+3]
        o[8*r +: 8] = x2[r] ^ (x2[(r+1)%4] ^ b[(r+1)%4]) ^ b[(r+2)%4] ^ b[(r+3)%4];
      end else begin
        // e*b[r] ^ b*b[r+1] ^ d*b[r+2] ^ 9*b[r+3]
        o[8*r +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                    ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ b[(r+1)%4])
                    ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ b[(r+2)%4])
                    ^ (x8[(r+3)%4] ^ b[(r+3)%4]);
      end
    end
    return o;
  endfunction

  logic [W-1:0] latch_in;

`ifdef XC_AESMIX_SEQ_SHIFTROWS_EN
  // Row r rotates by r columns: left for ShiftRows, right for InvShiftRows.
  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s, input logic fwd);
    logic [W-1:0] o;
    int           src;
    o = '0;
    for (int c = 0; c < NCOL; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = fwd ? ((c + r) % NCOL) : ((c + 4*NCOL - r) % NCOL);
        o[32*c + 8*r +: 8] = s[32*src + 8*r +: 8];
      end
    end
    return o;
  endfunction

  assign latch_in = bus.shift ? shift_rows(bus.state, bus.enc) : bus.state;
`else
  assign latch_in = bus.state;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dreg_q, dreg_d;
  logic          mreg_q, mreg_d;
  logic          ready_q, ready_d;
  logic [W-1:0]  result_q, result_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: dreg is a plain datapath register, but it is cleared here so no
      // operand survives a reset or abort.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dreg_q   <= '0;
      mreg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dreg_q   <= dreg_d;
      mreg_q   <= mreg_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    int col;
    // NOTE: every output gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    dreg_d   = dreg_q;
    mreg_d   = mreg_q;
    ready_d  = 1'b0;
    result_d = '0;
    col      = 0;
    unique case (state_q)
      S_IDLE: begin
        // While ready_q is high the requester's valid still belongs to the
        // operation just returned, so it is not a new request.
        if (bus.valid && !ready_q) begin
          dreg_d  = latch_in;
          mreg_d  = bus.enc;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!bus.valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          dreg_d  = '0;
        end else begin
          for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col = int'(cnt_q) + j;
            if (col < NCOL) begin
              dreg_d[32*col +: 32] = mix_col(dreg_q[32*col +: 32], mreg_q);
            end
          end
          cnt_d = cnt_q + CW'(COLS_PER_CYCLE);
          if (cnt_d == CW'(NCOL)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        ready_d  = 1'b1;
        result_d = dreg_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready  = ready_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_xc_aesmix_seq.sv
// ---------------------------------------------------------------------------
// tb_xc_aesmix_seq
// Directed vectors against two instances: dut_a (NCOL=4, one column/cycle)
// and dut_b (NCOL=4, two columns/cycle). Each request pushes its expected
// result and ready cycle into a per-DUT queue; a monitor per DUT pops and
// compares on every ready pulse and checks the result bus is zero otherwise.
// ---------------------------------------------------------------------------
module tb_xc_aesmix_seq;
  localparam int NCOL = 4;
  localparam int W    = 32 * NCOL;

  localparam logic [W-1:0] T1_IN  = {96'h0, 32'h305dbfd4};
  localparam logic [W-1:0] T1_OUT = {96'h0, 32'he5816604};
  localparam logic [W-1:0] T2_IN  = {32'h01010101, 32'h01010101, 32'h01010101, 32'he5816604};
  localparam logic [W-1:0] T2_OUT = {32'h01010101, 32'h01010101, 32'h01010101, 32'h305dbfd4};
  localparam logic [W-1:0] T3_IN  = {32'h4c31262d, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db};
  localparam logic [W-1:0] T3_OUT = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e};
  localparam logic [W-1:0] T5A_IN  = {32'hc6c6c6c6, 32'h455313db, 32'h00000000, 32'h5c220af2};
  localparam logic [W-1:0] T5A_OUT = {32'hc6c6c6c6, 32'hbca14d8e, 32'h00000000, 32'h9d58dc9f};
  localparam logic [W-1:0] T5B_IN  = {32'hd6d7d5d5, 32'hf8bd7e4d, 32'h01010101, 32'h00000000};
  localparam logic [W-1:0] T5B_OUT = {32'hd5d4d4d4, 32'h4c31262d, 32'h01010101, 32'h00000000};
  // FIPS-197 round 1: after SubBytes, after ShiftRows, after MixColumns.
  localparam logic [W-1:0] T6_RAW = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
  localparam logic [W-1:0] T6_SR  = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;
  localparam logic [W-1:0] T6_OUT = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  xc_aesmix_seq_if #(.NCOL(NCOL)) ia ();
  xc_aesmix_seq_if #(.NCOL(NCOL)) ib ();

  xc_aesmix_seq #(.NCOL(NCOL), .COLS_PER_CYCLE(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ia)
  );
  xc_aesmix_seq #(.NCOL(NCOL), .COLS_PER_CYCLE(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ib)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop on each ready pulse, otherwise require a zero result bus.
  always @(negedge clock) begin
    exp_t e;
    if (ia.ready === 1'b1) begin
      if (qa.size() == 0) begin
        check("a unexpected ready", W'(ia.ready), W'(0));
      end else begin
        e = qa.pop_front();
        check("a result", ia.result, e.res);
        check("a ready cycle", W'(cyc), W'(e.cyc));
      end
    end else begin
      check("a gated result", ia.result, '0);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (ib.ready === 1'b1) begin
      if (qb.size() == 0) begin
        check("b unexpected ready", W'(ib.ready), W'(0));
      end else begin
        e = qb.pop_front();
        check("b result", ib.result, e.res);
        check("b ready cycle", W'(cyc), W'(e.cyc));
      end
    end else begin
      check("b gated result", ib.result, '0);
    end
  end

  // Called just after a negedge. Presents a request, expects acceptance
  // acc_delay edges later and ready lat cycles after that; scrambles the
  // inputs once accepted; returns (valid still high) at the ready negedge.
  task automatic issue(input bit sel, input logic [W-1:0] st, input logic e,
                       input logic [W-1:0] exp, input int acc_delay, input int lat,
                       input string name);
    exp_t x;
    bit   seen;
    x.res = exp;
    x.cyc = cyc + acc_delay + lat;
    if (sel) begin
      ib.state = st; ib.enc = e; ib.valid = 1'b1; qb.push_back(x);
    end else begin
      ia.state = st; ia.enc = e; ia.valid = 1'b1; qa.push_back(x);
    end
    repeat (acc_delay) @(posedge clock);
    #1;
    if (sel) begin
      ib.state = ~st; ib.enc = ~e;
    end else begin
      ia.state = ~st; ia.enc = ~e;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = sel ? (ib.ready === 1'b1) : (ia.ready === 1'b1);
    end
    check({name, " ready seen"}, W'(seen), W'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    ia.valid = 1'b0; ia.enc = 1'b0; ia.state = '0;
    ib.valid = 1'b0; ib.enc = 1'b0; ib.state = '0;
`ifdef XC_AESMIX_SEQ_SHIFTROWS_EN
    ia.shift = 1'b0;
    ib.shift = 1'b1;
`endif
    repeat (2) @(negedge clock);
    check("reset ready a", W'(ia.ready), W'(0));
    check("reset result a", ia.result, '0);
    check("reset ready b", W'(ib.ready), W'(0));
    check("reset result b", ib.result, '0);
    reset = 1'b0;
    @(negedge clock);

    // 1: MixColumns of the FIPS column, latency 5.
    issue(1'b0, T1_IN, 1'b1, T1_OUT, 1, 5, "t1 enc");
    ia.valid = 1'b0;
    @(negedge clock);

    // 2: InvMixColumns back to the FIPS column, 01010101 is a fixed point.
    issue(1'b0, T2_IN, 1'b0, T2_OUT, 1, 5, "t2 dec");
    ia.valid = 1'b0;
    @(negedge clock);

    // 3: valid dropped before the second busy edge aborts silently.
    ia.state = T3_IN; ia.enc = 1'b1; ia.valid = 1'b1;
    repeat (2) @(negedge clock);
    ia.valid = 1'b0;
    repeat (8) @(negedge clock);
    issue(1'b0, T3_IN, 1'b1, T3_OUT, 1, 5, "t3 after abort");
    ia.valid = 1'b0;
    @(negedge clock);

    // 4: reset mid-busy, then an immediate accept.
    ia.state = T3_IN; ia.enc = 1'b1; ia.valid = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t4 ready after reset", W'(ia.ready), W'(0));
    check("t4 result after reset", ia.result, '0);
    reset = 1'b0;
    issue(1'b0, T3_OUT, 1'b0, T3_IN, 1, 5, "t4 after reset");
    ia.valid = 1'b0;
    @(negedge clock);

    // 5: valid held across two ops; second accept waits out the ready cycle.
    issue(1'b0, T5A_IN, 1'b1, T5A_OUT, 1, 5, "t5 op1");
    issue(1'b0, T5B_IN, 1'b0, T5B_OUT, 2, 5, "t5 op2");
    ia.valid = 1'b0;
    @(negedge clock);

    // 6: two columns per cycle, latency 3, FIPS round 1.
`ifdef XC_AESMIX_SEQ_SHIFTROWS_EN
    issue(1'b1, T6_RAW, 1'b1, T6_OUT, 1, 3, "t6 cpc2 shift");
`else
    issue(1'b1, T6_SR, 1'b1, T6_OUT, 1, 3, "t6 cpc2");
`endif
    ib.valid = 1'b0;
    @(negedge clock);
    issue(1'b1, T6_OUT, 1'b0, T6_SR, 1, 3, "t6 cpc2 dec");
    ib.valid = 1'b0;

    repeat (10) @(negedge clock);
    check("a queue drained", W'(qa.size()), W'(0));
    check("b queue drained", W'(qb.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
